// File: rtl/seqdet_pkg.sv
// Shared types and constants for the time-multiplexed "101" sequence detector.
package seqdet_pkg;

  typedef enum logic [1:0] {
    ST_S0 = 2'b00,
    ST_S1 = 2'b01,
    ST_S2 = 2'b10
  } state_t;

  localparam int unsigned     CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  typedef struct packed {
    state_t nxt;
    logic   hit;
  } step_t;

  // One detector step for a consumed bit.
  function automatic step_t seqdet_step(input state_t s, input logic b);
    step_t r;
    r.hit = 1'b0;
    case (s)
      ST_S1:   r.nxt = b ? ST_S1 : ST_S2;
      ST_S2: begin
        r.nxt = b ? ST_S1 : ST_S0;
        r.hit = b;
      end
      // ST_S0 and the unused 2'b11 encoding behave identically
      default: r.nxt = b ? ST_S1 : ST_S0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seqdet_scheduler_if.sv
// Requester/match/counter-read bundle for seqdet_scheduler.
interface seqdet_scheduler_if #(
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] req_valid;
  logic [NUM_CH-1:0] req_bit;
  logic [NUM_CH-1:0] req_ready;
  logic [NUM_CH-1:0] ch_clear;
  logic              match_valid;
  logic [CH_W-1:0]   match_ch;
  logic [CH_W-1:0]   cnt_sel;
  logic [7:0]        cnt_data;

  modport master (
    output req_valid, req_bit, ch_clear, cnt_sel,
    input  req_ready, match_valid, match_ch, cnt_data
  );

  modport slave (
    input  req_valid, req_bit, ch_clear, cnt_sel,
    output req_ready, match_valid, match_ch, cnt_data
  );

endinterface

// File: rtl/seqdet_scheduler_rr_arbiter.sv
// Round-robin arbiter: first eligible channel at or after rr_ptr, wrapping.
module seqdet_rr_arbiter #(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eligible_i,
  input  logic [CH_W-1:0]   rr_ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [CH_W-1:0]   grant_idx_o,
  output logic              any_grant_o
);

  logic [CH_W-1:0] idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = CH_W'((32'(rr_ptr_i) + k) % NUM_CH);
      if (!any_grant_o && eligible_i[idx]) begin
        any_grant_o  = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/seqdet_scheduler.sv
// Shared "101" overlapping detector serving NUM_CH serial requesters round-robin.
// Optional per-channel match counters: define SEQDET_MATCH_CNT_EN.
module seqdet_scheduler
  import seqdet_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input logic               clk,
  input logic               reset_n,
  seqdet_scheduler_if.slave bus
);

  state_t          state_q [NUM_CH];
  state_t          state_d [NUM_CH];
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            match_valid_q, match_valid_d;
  logic [CH_W-1:0] match_ch_q, match_ch_d;

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              any_grant;
  step_t             step;

  // Reset gates eligibility so no grant is shown while reset is held.
  assign eligible = bus.req_valid & ~bus.ch_clear & {NUM_CH{reset_n}};

  seqdet_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .eligible_i  (eligible),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  assign bus.req_ready   = grant;
  assign bus.match_valid = match_valid_q;
  assign bus.match_ch    = match_ch_q;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    match_valid_d = 1'b0;
    match_ch_d    = match_ch_q;
    step          = seqdet_step(state_q[grant_idx], bus.req_bit[grant_idx]);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.ch_clear[i]) state_d[i] = ST_S0;
    end
    if (any_grant) begin
      state_d[grant_idx] = step.nxt;
      match_valid_d      = step.hit;
      if (step.hit) match_ch_d = grant_idx;
      rr_ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) state_q[i] <= ST_S0;
      rr_ptr_q      <= '0;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
      rr_ptr_q      <= rr_ptr_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.ch_clear[i]) begin
        cnt_d[i] = '0;
      end else if (match_valid_d && grant_idx == CH_W'(i) && cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.cnt_data = (32'(bus.cnt_sel) < NUM_CH) ? cnt_q[bus.cnt_sel] : '0;
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^bus.cnt_sel;
  assign bus.cnt_data   = '0;
`endif

endmodule

// File: tb/tb_seqdet_scheduler.sv
// Randomized and directed bench for seqdet_scheduler against a bit-history model.
module tb_seqdet_scheduler;

  localparam int NCH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seqdet_scheduler_if #(.NUM_CH(NCH)) bus ();
  seqdet_scheduler #(.NUM_CH(NCH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: last three consumed bits per channel plus how many were consumed.
  int m_hist [NCH];
  int m_len  [NCH];
  int m_cnt  [NCH];
  int m_ptr;
  int m_mv;
  int m_ch;
  int obs_match;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int sel);
`ifdef SEQDET_MATCH_CNT_EN
    return m_cnt[sel];
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_hist[i] = 0; m_len[i] = 0; m_cnt[i] = 0;
    end
    m_ptr = 0; m_mv = 0; m_ch = 0;
  endtask

  task automatic do_reset(input logic [1:0] sel);
    @(negedge clk);
    reset_n = 1'b0;
    bus.req_valid = '1; bus.req_bit = '1; bus.ch_clear = '0; bus.cnt_sel = sel;
    model_reset();
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_match_valid", bus.match_valid, 0);
    check("rst_match_ch", bus.match_ch, 0);
    check("rst_cnt_data", bus.cnt_data, 0);
    @(negedge clk);
    bus.req_valid = '0;
    reset_n = 1'b1;
  endtask

  task automatic drive_cycle(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c,
                             input logic [1:0] sel, output int g);
    int idx;
    @(negedge clk);
    bus.req_valid = v; bus.req_bit = b; bus.ch_clear = c; bus.cnt_sel = sel;
    #1;
    g = -1;
    for (int k = 0; k < NCH; k++) begin
      idx = (m_ptr + k) % NCH;
      if (g < 0 && v[idx] && !c[idx]) g = idx;
    end
    check("req_ready", bus.req_ready, (g < 0) ? 0 : (1 << g));
    check("cnt_data", bus.cnt_data, exp_cnt(sel));
    @(posedge clk);
    for (int i = 0; i < NCH; i++) begin
      if (c[i]) begin m_hist[i] = 0; m_len[i] = 0; m_cnt[i] = 0; end
    end
    m_mv = 0;
    if (g >= 0) begin
      m_hist[g] = ((m_hist[g] << 1) | int'(b[g])) & 7;
      m_len[g]++;
      if (m_len[g] >= 3 && m_hist[g] == 5) begin
        m_mv = 1; m_ch = g;
        if (m_cnt[g] < 255) m_cnt[g]++;
      end
      m_ptr = (g + 1) % NCH;
    end
    #1;
    check("match_valid", bus.match_valid, m_mv);
    check("match_ch", bus.match_ch, m_ch);
    if (bus.match_valid === 1'b1) obs_match++;
  endtask

  // Feed one bit on a single channel with all others idle.
  task automatic feed(input int ch, input logic bitv, input logic [1:0] sel);
    int g;
    drive_cycle(4'(1 << ch), bitv ? 4'(1 << ch) : 4'b0, 4'b0, sel, g);
  endtask

  initial begin : main
    int g, base;
    logic [3:0] pv, pb, cl;
    bus.req_valid = '0; bus.req_bit = '0; bus.ch_clear = '0; bus.cnt_sel = '0;
    obs_match = 0;
    model_reset();

    do_reset(2'd0);

    // Single channel 2: 1,0,1,0,1 gives two matches
    base = obs_match;
    feed(2, 1, 2); feed(2, 0, 2); feed(2, 1, 2); feed(2, 0, 2); feed(2, 1, 2);
    check("ch2_match_count", obs_match - base, 2);
    drive_cycle(4'b0, 4'b0, 4'b0, 2'd2, g);
`ifdef SEQDET_MATCH_CNT_EN
    check("ch2_cnt", bus.cnt_data, 2);
`else
    check("ch2_cnt", bus.cnt_data, 0);
`endif

    // All channels valid: strict 0,1,2,3 rotation; channel 1 streams 1,0,1
    do_reset(2'd1);
    base = obs_match;
    for (int k = 0; k < 12; k++) begin
      pb = 4'b0000;
      pb[1] = (k / 4 == 1) ? 1'b0 : 1'b1;
      drive_cycle(4'b1111, pb, 4'b0, 2'd1, g);
      check("rr_order", g, k % 4);
    end
    check("ch1_first_match", obs_match - base >= 1, 1);

    // Clear wins over a same-cycle bit on channel 0 in S2
    do_reset(2'd0);
    feed(0, 1, 0); feed(0, 0, 0);
    base = obs_match;
    drive_cycle(4'b0001, 4'b0001, 4'b0001, 2'd0, g);
    check("clr_no_match", obs_match - base, 0);
    feed(0, 1, 0); feed(0, 0, 0); feed(0, 1, 0);
    check("clr_then_match", obs_match - base, 1);

    // Mid-stream reset discards channel 3's "10"
    do_reset(2'd3);
    feed(3, 1, 3); feed(3, 0, 3);
    do_reset(2'd3);
    base = obs_match;
    feed(3, 1, 3);
    check("rst_discard", obs_match - base, 0);
    feed(3, 0, 3); feed(3, 1, 3);
    check("rst_fresh_match", obs_match - base, 1);

    // 300 matches on channel 1 saturate the counter
    do_reset(2'd1);
    base = obs_match;
    feed(1, 1, 1);
    for (int k = 0; k < 300; k++) begin
      feed(1, 0, 1); feed(1, 1, 1);
    end
    check("sat_match_count", obs_match - base, 300);
    drive_cycle(4'b0, 4'b0, 4'b0, 2'd1, g);
`ifdef SEQDET_MATCH_CNT_EN
    check("cnt_sat", bus.cnt_data, 255);
`else
    check("cnt_sat", bus.cnt_data, 0);
`endif

    // Random traffic with held requests, sporadic clears and a reset
    pv = '0; pb = '0;
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        do_reset(2'(n));
        pv = '0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i] = 1'b1;
          pb[i] = 1'($urandom_range(0, 1));
        end
      end
      cl = '0;
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 15) == 0) cl[i] = 1'b1;
      drive_cycle(pv, pb, cl, 2'($urandom_range(0, 3)), g);
      if (g >= 0) pv[g] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
